// File: rtl/tennis_pkg.sv
// Shared phase encoding and default screen/paddle geometry for the tennis controller.
package tennis_pkg;

    typedef enum logic [1:0] {
        PH_IDLE  = 2'd0,
        PH_SERVE = 2'd1,
        PH_PLAY  = 2'd2,
        PH_OVER  = 2'd3
    } phase_t;

    localparam int DEF_H_RES      = 640;
    localparam int DEF_V_RES      = 480;
    localparam int DEF_BALL_SIZE  = 8;
    localparam int DEF_PADDLE_W   = 8;
    localparam int DEF_PADDLE_H   = 64;
    localparam int DEF_PADDLE_X_L = 16;
    localparam int DEF_PADDLE_X_R = 616;
    localparam int SPEED_MAX      = 4;

    localparam int CENTRE_X = (DEF_H_RES - DEF_BALL_SIZE) / 2;
    localparam int CENTRE_Y = (DEF_V_RES - DEF_BALL_SIZE) / 2;

    function automatic logic [9:0] centre(input int res, input int size);
        return 10'((res - size) / 2);
    endfunction

endpackage

// File: rtl/tennis_collide.sv
// Combinational next-position, wall bounce, paddle hit and miss evaluation for one ball step.
module tennis_collide
    import tennis_pkg::*;
#(
    parameter int H_RES      = DEF_H_RES,
    parameter int V_RES      = DEF_V_RES,
    parameter int BALL_SIZE  = DEF_BALL_SIZE,
    parameter int PADDLE_W   = DEF_PADDLE_W,
    parameter int PADDLE_H   = DEF_PADDLE_H,
    parameter int PADDLE_X_L = DEF_PADDLE_X_L,
    parameter int PADDLE_X_R = DEF_PADDLE_X_R
) (
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       dx,
    input  logic       dy,
    input  logic [2:0] speed,
    input  logic [9:0] paddle_l_y,
    input  logic [9:0] paddle_r_y,
    output logic [9:0] x_next,
    output logic [9:0] y_next,
    output logic       dx_next,
    output logic       dy_next,
    output logic       hit,
    output logic       miss_l,
    output logic       miss_r
);
    localparam logic signed [10:0] X_HIT_L = 11'(PADDLE_X_L + PADDLE_W);
    localparam logic signed [10:0] X_HIT_R = 11'(PADDLE_X_R - BALL_SIZE);
    localparam logic signed [10:0] X_MAX   = 11'(H_RES - BALL_SIZE);
    localparam logic signed [10:0] Y_MAX   = 11'(V_RES - BALL_SIZE);
    localparam logic signed [10:0] BALL_S  = 11'(BALL_SIZE);
    localparam logic signed [10:0] PAD_XR  = 11'(PADDLE_X_R);

    logic signed [10:0] step, sx, sy, nx, ny;
    logic [10:0] y_ext, pl_ext, pr_ext;
    logic overlap_l, overlap_r, hit_l, hit_r;

    // One extra bit keeps the step from wrapping past either screen edge.
    assign step = signed'({8'd0, speed});
    assign sx   = signed'({1'b0, x});
    assign sy   = signed'({1'b0, y});
    assign nx   = dx ? sx + step : sx - step;
    assign ny   = dy ? sy + step : sy - step;

    assign y_ext     = {1'b0, y};
    assign pl_ext    = {1'b0, paddle_l_y};
    assign pr_ext    = {1'b0, paddle_r_y};
    assign overlap_l = (y_ext + 11'(BALL_SIZE) > pl_ext) && (y_ext < pl_ext + 11'(PADDLE_H));
    assign overlap_r = (y_ext + 11'(BALL_SIZE) > pr_ext) && (y_ext < pr_ext + 11'(PADDLE_H));

    assign hit_l  = !dx && (nx <= X_HIT_L) && overlap_l;
    assign hit_r  = dx && (nx + BALL_S >= PAD_XR) && overlap_r;
    assign miss_l = !hit_l && (nx <= 11'sd0);
    assign miss_r = !hit_r && (nx >= X_MAX);
    assign hit    = hit_l | hit_r;

    always_comb begin
        y_next  = ny[9:0];
        dy_next = dy;
        if (ny <= 11'sd0) begin
            y_next  = '0;
            dy_next = 1'b1;
        end else if (ny >= Y_MAX) begin
            y_next  = Y_MAX[9:0];
            dy_next = 1'b0;
        end
    end

    always_comb begin
        x_next  = nx[9:0];
        dx_next = dx;
        if (hit_l) begin
            x_next  = X_HIT_L[9:0];
            dx_next = 1'b1;
        end else if (hit_r) begin
            x_next  = X_HIT_R[9:0];
            dx_next = 1'b0;
        end
    end

endmodule

// File: rtl/tennis_game_sequencer.sv
// Frame-rate tennis controller: ball motion, scoring and idle/serve/play/over sequencing.
// Optional TENNIS_SPEEDUP_EN adds a paddle-hit counter that raises ball speed on every fourth hit.
module tennis_game_sequencer
    import tennis_pkg::*;
#(
    parameter int H_RES        = DEF_H_RES,
    parameter int V_RES        = DEF_V_RES,
    parameter int BALL_SIZE    = DEF_BALL_SIZE,
    parameter int PADDLE_W     = DEF_PADDLE_W,
    parameter int PADDLE_H     = DEF_PADDLE_H,
    parameter int PADDLE_X_L   = DEF_PADDLE_X_L,
    parameter int PADDLE_X_R   = DEF_PADDLE_X_R,
    parameter int BALL_SPEED   = 2,
    parameter int SERVE_FRAMES = 60,
    parameter int WIN_SCORE    = 7
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start,
    input  logic [9:0] paddle_l_y,
    input  logic [9:0] paddle_r_y,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic [1:0] phase,
    output logic       game_over
);
    localparam int CNT_W = $clog2(SERVE_FRAMES + 1);
    localparam logic [9:0] CX = centre(H_RES, BALL_SIZE);
    localparam logic [9:0] CY = centre(V_RES, BALL_SIZE);

    phase_t phase_q, phase_d;
    logic dx_q, dy_q;
    logic [CNT_W-1:0] serve_cnt;
    logic [2:0] speed;
    logic [9:0] x_next, y_next;
    logic dx_next, dy_next, hit, miss_l, miss_r;
    logic serve_done, play_tick, point, game_won;

    tennis_collide #(
        .H_RES(H_RES), .V_RES(V_RES), .BALL_SIZE(BALL_SIZE), .PADDLE_W(PADDLE_W),
        .PADDLE_H(PADDLE_H), .PADDLE_X_L(PADDLE_X_L), .PADDLE_X_R(PADDLE_X_R)
    ) u_collide (
        .x(ball_x), .y(ball_y), .dx(dx_q), .dy(dy_q), .speed(speed),
        .paddle_l_y(paddle_l_y), .paddle_r_y(paddle_r_y),
        .x_next(x_next), .y_next(y_next), .dx_next(dx_next), .dy_next(dy_next),
        .hit(hit), .miss_l(miss_l), .miss_r(miss_r)
    );

    assign serve_done = (phase_q == PH_SERVE) && frame_tick &&
                        (serve_cnt == CNT_W'(SERVE_FRAMES - 1));
    assign play_tick  = (phase_q == PH_PLAY) && frame_tick;
    assign point      = play_tick && (miss_l || miss_r);
    assign game_won   = (miss_l && (score_r == 4'(WIN_SCORE - 1))) ||
                        (miss_r && (score_l == 4'(WIN_SCORE - 1)));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) phase_q <= PH_IDLE;
        else       phase_q <= phase_d;
    end

    always_comb begin
        phase_d = phase_q;
        case (phase_q)
            PH_IDLE, PH_OVER: if (start) phase_d = PH_SERVE;
            PH_SERVE:         if (serve_done) phase_d = PH_PLAY;
            PH_PLAY:          if (point) phase_d = game_won ? PH_OVER : PH_SERVE;
            default:          phase_d = phase_q;
        endcase
    end

    always_comb begin
        phase     = phase_q;
        game_over = (phase_q == PH_OVER);
    end

    // A start pulse restarts the serve count, so a coincident tick is never counted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ball_x    <= CX;
            ball_y    <= CY;
            dx_q      <= 1'b1;
            dy_q      <= 1'b1;
            score_l   <= '0;
            score_r   <= '0;
            serve_cnt <= '0;
        end else begin
            case (phase_q)
                PH_IDLE, PH_OVER: if (start) begin
                    score_l   <= '0;
                    score_r   <= '0;
                    dx_q      <= 1'b1;
                    serve_cnt <= '0;
                    ball_x    <= CX;
                    ball_y    <= CY;
                end
                PH_SERVE: if (frame_tick) begin
                    serve_cnt <= serve_done ? '0 : serve_cnt + CNT_W'(1);
                end
                PH_PLAY: if (frame_tick) begin
                    if (point) begin
                        ball_x    <= CX;
                        ball_y    <= CY;
                        serve_cnt <= '0;
                        dx_q      <= miss_r;
                        score_l   <= score_l + {3'b000, miss_r};
                        score_r   <= score_r + {3'b000, miss_l};
                    end else begin
                        ball_x <= x_next;
                        ball_y <= y_next;
                        dx_q   <= dx_next;
                        dy_q   <= dy_next;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef TENNIS_SPEEDUP_EN
    logic [1:0] hit_cnt;
    logic [2:0] speed_q;
    logic       enter_serve;

    assign enter_serve = (phase_d == PH_SERVE) && (phase_q != PH_SERVE);
    assign speed       = speed_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hit_cnt <= '0;
            speed_q <= 3'(BALL_SPEED);
        end else if (enter_serve) begin
            hit_cnt <= '0;
            speed_q <= 3'(BALL_SPEED);
        end else if (play_tick && hit) begin
            hit_cnt <= hit_cnt + 2'd1;
            if ((hit_cnt == 2'd3) && (speed_q < 3'(SPEED_MAX))) speed_q <= speed_q + 3'd1;
        end
    end
`else
    logic hit_unused;
    assign hit_unused = hit;
    assign speed      = 3'(BALL_SPEED);
`endif

endmodule

// File: tb/tb_tennis_game_sequencer.sv
// Bench for tennis_game_sequencer: fixed serve/play vectors, a modelled full game and reset/restart corners.
module tb_tennis_game_sequencer;
    localparam int W = 31;

    logic       clock = 1'b0;
    logic       reset;
    logic       frame_tick;
    logic       start;
    logic [9:0] paddle_l_y;
    logic [9:0] paddle_r_y;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic [3:0] score_l;
    logic [3:0] score_r;
    logic [1:0] phase;
    logic       game_over;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    int m_ph, m_x, m_y, m_dx, m_dy, m_sl, m_sr, m_cnt, m_spd, m_hits;

    typedef struct {
        bit st;
        bit tk;
        int reps;
        int ph;
        int x;
        int y;
    } vec_t;
    vec_t vecs[9];

    tennis_game_sequencer dut (
        .clock(clock), .reset(reset), .frame_tick(frame_tick), .start(start),
        .paddle_l_y(paddle_l_y), .paddle_r_y(paddle_r_y),
        .ball_x(ball_x), .ball_y(ball_y), .score_l(score_l), .score_r(score_r),
        .phase(phase), .game_over(game_over)
    );

    always #10 clock = ~clock;

    function automatic logic [W-1:0] pack_exp(input int x, input int y, input int sl,
                                              input int sr, input int ph);
        return {x[9:0], y[9:0], sl[3:0], sr[3:0], ph[1:0], (ph == 3)};
    endfunction

    function automatic int track_y(input int y);
        return (y >= 28) ? y - 28 : 0;
    endfunction

    function automatic int far_y(input int y);
        return (y < 200) ? 300 : 0;
    endfunction

    task automatic check_out(input string name);
        logic [W-1:0] e, g;
        g = {ball_x, ball_y, score_l, score_r, phase, game_over};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: no expected entry queued", name);
            return;
        end
        e = exp_q.pop_front();
        if (g !== e) begin
            errors++;
            $display("FAIL %s: got x=%0d y=%0d sl=%0d sr=%0d ph=%0d go=%0d want x=%0d y=%0d sl=%0d sr=%0d ph=%0d go=%0d",
                     name, g[30:21], g[20:11], g[10:7], g[6:3], g[2:1], g[0],
                     e[30:21], e[20:11], e[10:7], e[6:3], e[2:1], e[0]);
        end
    endtask

    task automatic step(input bit st, input bit tk, input int pl, input int pr,
                        input logic [W-1:0] e, input string name);
        start      = st;
        frame_tick = tk;
        paddle_l_y = pl[9:0];
        paddle_r_y = pr[9:0];
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        check_out(name);
    endtask

    task automatic serve_reset();
        m_spd  = 2;
        m_hits = 0;
    endtask

    task automatic model_step(input bit st, input bit tk, input int pl, input int pr);
        int nx, ny;
        bit ovl, ovr, hl, hr, ml, mr;
        case (m_ph)
            0, 3: if (st) begin
                m_ph = 1; m_sl = 0; m_sr = 0; m_dx = 1; m_cnt = 0; m_x = 316; m_y = 236;
                serve_reset();
            end
            1: if (tk) begin
                m_cnt++;
                if (m_cnt == 60) begin m_ph = 2; m_cnt = 0; end
            end
            default: if (tk) begin
                nx  = m_x + m_dx * m_spd;
                ny  = m_y + m_dy * m_spd;
                ovl = (m_y + 8 > pl) && (m_y < pl + 64);
                ovr = (m_y + 8 > pr) && (m_y < pr + 64);
                hl  = (m_dx < 0) && (nx <= 24) && ovl;
                hr  = (m_dx > 0) && (nx + 8 >= 616) && ovr;
                ml  = !hl && (nx <= 0);
                mr  = !hr && (nx >= 632);
                if (ml || mr) begin
                    if (ml) m_sr++; else m_sl++;
                    m_x = 316; m_y = 236; m_cnt = 0;
                    m_dx = ml ? -1 : 1;
                    m_ph = (m_sl == 7 || m_sr == 7) ? 3 : 1;
                    if (m_ph == 1) serve_reset();
                end else begin
                    if (ny <= 0) begin m_y = 0; m_dy = 1; end
                    else if (ny >= 472) begin m_y = 472; m_dy = -1; end
                    else m_y = ny;
                    if (hl) begin m_x = 24; m_dx = 1; end
                    else if (hr) begin m_x = 608; m_dx = -1; end
                    else m_x = nx;
`ifdef TENNIS_SPEEDUP_EN
                    if (hl || hr) begin
                        m_hits = (m_hits + 1) % 4;
                        if (m_hits == 0 && m_spd < 4) m_spd++;
                    end
`endif
                end
            end
        endcase
    endtask

    function automatic logic [W-1:0] pack_model();
        return pack_exp(m_x, m_y, m_sl, m_sr, m_ph);
    endfunction

    initial begin
        int loser, cyc, pl, pr;
        bit st, tk;
        reset = 1'b1; start = 1'b0; frame_tick = 1'b0; paddle_l_y = '0; paddle_r_y = '0;
        @(posedge clock);
        #1;
        exp_q.push_back(pack_exp(316, 236, 0, 0, 0));
        check_out("reset_state");
        @(negedge clock);
        reset = 1'b0;

        vecs[0] = '{st: 0, tk: 0, reps: 1,  ph: 0, x: 316, y: 236};
        vecs[1] = '{st: 0, tk: 1, reps: 2,  ph: 0, x: 316, y: 236};
        vecs[2] = '{st: 1, tk: 1, reps: 1,  ph: 1, x: 316, y: 236};
        vecs[3] = '{st: 0, tk: 1, reps: 59, ph: 1, x: 316, y: 236};
        vecs[4] = '{st: 0, tk: 1, reps: 1,  ph: 2, x: 316, y: 236};
        vecs[5] = '{st: 0, tk: 0, reps: 3,  ph: 2, x: 316, y: 236};
        vecs[6] = '{st: 1, tk: 0, reps: 1,  ph: 2, x: 316, y: 236};
        vecs[7] = '{st: 0, tk: 1, reps: 1,  ph: 2, x: 318, y: 238};
        vecs[8] = '{st: 1, tk: 1, reps: 1,  ph: 2, x: 320, y: 240};
        for (int i = 0; i < 9; i++) begin
            for (int r = 0; r < vecs[i].reps; r++) begin
                step(vecs[i].st, vecs[i].tk, 0, 0,
                     pack_exp(vecs[i].x, vecs[i].y, 0, 0, vecs[i].ph), $sformatf("vec%0d", i));
            end
        end

        m_ph = 2; m_x = 320; m_y = 240; m_dx = 1; m_dy = 1;
        m_sl = 0; m_sr = 0; m_cnt = 0; m_spd = 2; m_hits = 0;

        // Full game: the winner of each point tracks the ball, the loser stays out of reach.
        cyc = 0;
        loser = 0;
        while (m_ph != 3 && cyc < 60000) begin
            if (m_ph != 2) loser = $urandom_range(0, 1);
            st = ($urandom_range(0, 40) == 0);
            tk = ($urandom_range(0, 3) != 0);
            pl = (loser == 0) ? far_y(m_y) : track_y(m_y);
            pr = (loser == 1) ? far_y(m_y) : track_y(m_y);
            model_step(st, tk, pl, pr);
            step(st, tk, pl, pr, pack_model(), "rally");
            cyc++;
        end
        checks++;
        if (phase !== 2'd3 || game_over !== 1'b1) begin
            errors++;
            $display("FAIL game_end: got phase=%0d game_over=%0d want phase=3 game_over=1 within budget",
                     phase, game_over);
        end

        for (int i = 0; i < 3; i++) begin
            model_step(0, 1, 0, 0);
            step(0, 1, 0, 0, pack_model(), "over_frozen");
        end

        model_step(1, 1, 0, 0);
        step(1, 1, 0, 0, pack_exp(316, 236, 0, 0, 1), "over_restart");
        for (int i = 0; i < 59; i++) begin
            model_step(0, 1, 0, 0);
            step(0, 1, 0, 0, pack_exp(316, 236, 0, 0, 1), "serve_hold");
        end
        model_step(0, 1, 0, 0);
        step(0, 1, 0, 0, pack_exp(316, 236, 0, 0, 2), "serve_end");

        for (int i = 0; i < 40; i++) begin
            pl = track_y(m_y);
            pr = track_y(m_y);
            model_step(0, 1, pl, pr);
            step(0, 1, pl, pr, pack_model(), "play_after_restart");
        end

        #4;
        reset = 1'b1;
        #1;
        exp_q.push_back(pack_exp(316, 236, 0, 0, 0));
        check_out("async_reset");
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        step(0, 1, 0, 0, pack_exp(316, 236, 0, 0, 0), "post_reset_tick");
        step(1, 0, 0, 0, pack_exp(316, 236, 0, 0, 1), "post_reset_start");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
